// File: rtl/banco_reg_nport.sv
// ============================================================================
// banco_reg_nport : DEPTH x WIDTH register bank, NUM_RD registered read ports,
//                   one write port, write-to-read bypass and clear-all sweep.
// Revision 1.0
// ============================================================================
`default_nettype none

module banco_reg_nport #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     clr,
  output logic                     busy
);

  localparam logic [0:0]        c_idle  = 1'b0;
  localparam logic [0:0]        c_clear = 1'b1;
  localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_ctr;
  logic              r_busy;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic w_wr_zero;
  logic w_wr_accept;

  assign w_wr_zero   = (ZERO_REG != 0) && (wr_addr == '0);
  // clr wins over a coincident write; nothing is written while sweeping
  assign w_wr_accept = wr_en && (r_state == c_idle) && !clr && !w_wr_zero;
  assign busy        = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
      r_ctr   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (clr) begin
            r_state <= c_clear;
            r_ctr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        c_clear: begin
          r_ctr <= r_ctr + 1'b1;
          if (r_ctr == c_last) begin
            r_state <= c_idle;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= c_idle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else if (r_state == c_clear) begin
      r_mem[r_ctr] <= '0;
    end else if (w_wr_accept) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [WIDTH-1:0]  w_rdata;
    logic [WIDTH-1:0]  r_data;
    logic              r_valid;

    assign w_addr = rd_addr[i*ADDR_W +: ADDR_W];

    // Sweep zeroing is never forwarded: during CLEAR no write is accepted
    always_comb begin
      w_rdata = r_mem[w_addr];
      if ((ZERO_REG != 0) && (w_addr == '0)) begin
        w_rdata = '0;
      end else if ((BYPASS != 0) && w_wr_accept && (wr_addr == w_addr)) begin
        w_rdata = wr_data;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= rd_en[i];
        if (rd_en[i]) begin
          r_data <= w_rdata;
        end
      end
    end

    assign rd_data[i*WIDTH +: WIDTH] = r_data;
    assign rd_valid[i]               = r_valid;
  end

endmodule

`default_nettype wire

// File: tb/tb_banco_reg_nport.sv
// ============================================================================
// tb_banco_reg_nport : directed self-checking bench, 4 read ports, zero reg and bypass on.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_banco_reg_nport;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [WIDTH-1:0]         wr_data;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*WIDTH-1:0]  rd_data;
  logic [NUM_RD-1:0]        rd_valid;
  logic                     clr;
  logic                     busy;

  int checks = 0;
  int errors = 0;

  banco_reg_nport #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr(clr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input logic [3:0] en, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] a3);
    rd_en   = en;
    rd_addr = {a3, a2, a1, a0};
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr = 1'b0;
    set_rd(4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_busy", {127'b0, busy}, 128'd0);
    chk("reset_valid", {124'b0, rd_valid}, 128'd0);
    chk("reset_data", rd_data, 128'd0);

    // basic write then read
    wr(5'd5, 32'hDEADBEEF);
    set_rd(4'b0001, 5'd5, 5'd0, 5'd0, 5'd0);
    tick();
    chk("wr_rd_data", {96'b0, rd_data[31:0]}, {96'b0, 32'hDEADBEEF});
    chk("wr_rd_valid", {124'b0, rd_valid}, {124'b0, 4'b0001});

    // register 0 stays zero on every port
    set_rd(4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
    wr(5'd0, 32'hFFFFFFFF);
    set_rd(4'b1111, 5'd0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("zero_reg_data", rd_data, 128'd0);
    chk("zero_reg_valid", {124'b0, rd_valid}, {124'b0, 4'b1111});

    // same-cycle write forwarded to two ports
    set_rd(4'b0011, 5'd7, 5'd7, 5'd0, 5'd0);
    wr(5'd7, 32'h12345678);
    chk("bypass_p0", {96'b0, rd_data[31:0]}, {96'b0, 32'h12345678});
    chk("bypass_p1", {96'b0, rd_data[63:32]}, {96'b0, 32'h12345678});
    set_rd(4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("idle_valid", {124'b0, rd_valid}, 128'd0);
    chk("idle_hold_p1", {96'b0, rd_data[63:32]}, {96'b0, 32'h12345678});

    // multi-port, port 3 disabled keeps its old data
    wr(5'd1, 32'h11111111);
    wr(5'd2, 32'h22222222);
    wr(5'd3, 32'h33333333);
    wr(5'd31, 32'hA5A5A5A5);
    set_rd(4'b1000, 5'd0, 5'd0, 5'd0, 5'd5);
    tick();
    set_rd(4'b0111, 5'd1, 5'd2, 5'd3, 5'd31);
    tick();
    chk("mp_data", rd_data, {32'hDEADBEEF, 32'h33333333, 32'h22222222, 32'h11111111});
    chk("mp_valid", {124'b0, rd_valid}, {124'b0, 4'b0111});
    set_rd(4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);

    // clear sweep: fill, then clr together with a write that must be dropped
    for (int a = 0; a < DEPTH; a++) wr(5'(a), 32'h10000000 | a);
    clr = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000BAD;
    set_rd(4'b0011, 5'd9, 5'd31, 5'd0, 5'd0);
    tick();
    n = busy ? 1 : 0;
    chk("clr_read_old9", {96'b0, rd_data[31:0]}, {96'b0, 32'h10000009});
    clr = 1'b0; wr_addr = 5'd10;
    tick();
    if (busy) n++;
    chk("clear_read_old31", {96'b0, rd_data[63:32]}, {96'b0, 32'h1000001F});
    set_rd(4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
    for (int k = 0; k < 100 && busy; k++) begin
      tick();
      if (busy) n++;
    end
    wr_en = 1'b0;
    chk("busy_cycles", 128'(n), 128'd32);
    chk("busy_done", {127'b0, busy}, 128'd0);
    for (int a = 0; a < DEPTH; a += 4) begin
      set_rd(4'b1111, 5'(a), 5'(a + 1), 5'(a + 2), 5'(a + 3));
      tick();
      chk($sformatf("cleared_%0d", a), rd_data, 128'd0);
    end

    // async reset in the middle of a sweep
    wr(5'd4, 32'h44444444);
    wr(5'd30, 32'h30303030);
    set_rd(4'b0001, 5'd4, 5'd0, 5'd0, 5'd0);
    tick();
    chk("pre_rst_data", {96'b0, rd_data[31:0]}, {96'b0, 32'h44444444});
    set_rd(4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    chk("mid_sweep_busy", {127'b0, busy}, 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", {127'b0, busy}, 128'd0);
    chk("async_rst_valid", {124'b0, rd_valid}, 128'd0);
    chk("async_rst_data", rd_data, 128'd0);
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a += 4) begin
      set_rd(4'b1111, 5'(a), 5'(a + 1), 5'(a + 2), 5'(a + 3));
      tick();
      chk($sformatf("post_rst_%0d", a), rd_data, 128'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
